stoch_sub: RTL and testbench

- Subtracts one stochastic bitstream from another: output bit-rate is max(pa − pb, 0), where pa and pb are the probabilities of a 1 on inputs a and b.
- Companion to the stochastic adder in the same library. The adder carries surplus ones forward; this block carries both credit and debt in a signed saturating counter.
- Sits in datapaths between stochastic number generators and estimators, one bit per enabled clock.

---
 rtl/stoch_sub.sv | 76 +++++++
 tb/tb_stoch_sub.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stoch_sub.sv
// Stochastic subtractor: y carries max(pa - pb, 0) via a signed saturating credit/debt counter.
// Define STOCH_SUB_SAT_FLAG_EN to add the sticky lower-saturation flag (sat, sat_clr).
module stoch_sub #(
  parameter int COUNTER_SIZE = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic a,
  input  logic b,
`ifdef STOCH_SUB_SAT_FLAG_EN
  input  logic sat_clr,
  output logic sat,
`endif
  output logic y,
  output logic neg
);

  localparam int N = COUNTER_SIZE;
  localparam int W = COUNTER_SIZE + 2;
  localparam logic signed [W-1:0] CntMin = {{3{1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [W-1:0] CntMax = {3'b000, {(N-1){1'b1}}};

  logic [N-1:0]        cnt_q, cnt_d;
  logic signed [W-1:0] cnt_ext, a_ext, b_ext, y_ext, sum, nxt;
  logic                pos;

  // Two guard bits keep counter + a - b - y from ever wrapping before the clamp.
  always_comb begin
    cnt_ext = {{2{cnt_q[N-1]}}, cnt_q};
    a_ext   = {{(W-1){1'b0}}, a};
    b_ext   = {{(W-1){1'b0}}, b};
    sum     = cnt_ext + a_ext - b_ext;
    pos     = ~sum[W-1] & (|sum);
    y       = nRST & en & pos;
    y_ext   = {{(W-1){1'b0}}, y};
    nxt     = sum - y_ext;
    cnt_d   = nxt[N-1:0];
    if (nxt < CntMin) begin
      cnt_d = CntMin[N-1:0];
    end else if (nxt > CntMax) begin
      cnt_d = CntMax[N-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign neg = cnt_q[N-1];

`ifdef STOCH_SUB_SAT_FLAG_EN
  logic clamp_lo;
  logic sat_q;

  assign clamp_lo = en & (nxt < CntMin);

  // A clamp on the same edge as sat_clr keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sat_q <= 1'b0;
    end else if (clamp_lo) begin
      sat_q <= 1'b1;
    end else if (sat_clr) begin
      sat_q <= 1'b0;
    end
  end

  assign sat = sat_q;
`endif

endmodule

// File: tb/tb_stoch_sub.sv
// Scoreboard bench for stoch_sub: an N=8 instance for the main function and an N=4 instance
// for saturation; sat checks are active when STOCH_SUB_SAT_FLAG_EN is defined.
module tb_stoch_sub;

  logic CLK, nRST, en, a, b, sat_clr;
  logic y8, neg8, y4, neg4;
`ifdef STOCH_SUB_SAT_FLAG_EN
  logic sat8, sat4;
`endif

  stoch_sub #(.COUNTER_SIZE(8)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .en      (en),
    .a       (a),
    .b       (b),
`ifdef STOCH_SUB_SAT_FLAG_EN
    .sat_clr (sat_clr),
    .sat     (sat8),
`endif
    .y       (y8),
    .neg     (neg8)
  );

  stoch_sub #(.COUNTER_SIZE(4)) dut4 (
    .CLK     (CLK),
    .nRST    (nRST),
    .en      (en),
    .a       (a),
    .b       (b),
`ifdef STOCH_SUB_SAT_FLAG_EN
    .sat_clr (sat_clr),
    .sat     (sat4),
`endif
    .y       (y4),
    .neg     (neg4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic  sel;   // 0: N=8 instance, 1: N=4 instance
    logic  y;
    logic  neg;
    logic  cn;
    logic  sat;
    logic  cs;
    string nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        mx;
  int          vectors = 0;
  int          miscompares = 0;
  int          ones = 0;
  int          run_ones;
  logic        stat_on = 1'b0;
  logic        yv, nv;
  logic [11:0] la, lb;

  task automatic vec(input logic r, e, ai, bi, clr, sel, ey, eneg, cn, esat, cs,
                     input string nm);
    exp_t x;
    @(posedge CLK);
    #1;
    nRST = r; en = e; a = ai; b = bi; sat_clr = clr;
    x.sel = sel; x.y = ey; x.neg = eneg; x.cn = cn; x.sat = esat; x.cs = cs; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic vec8(input logic r, e, ai, bi, ey, eneg, cn, input string nm);
    vec(r, e, ai, bi, 1'b0, 1'b0, ey, eneg, cn, 1'b0, 1'b0, nm);
  endtask

  task automatic vec4(input logic ai, bi, clr, ey, eneg, esat, input string nm);
    vec(1'b1, 1'b1, ai, bi, clr, 1'b1, ey, eneg, 1'b1, esat, 1'b1, nm);
  endtask

  function automatic logic [11:0] lfsr_a(input logic [11:0] r);
    return {r[10:0], r[11] ^ r[10] ^ r[9] ^ r[3]};
  endfunction

  function automatic logic [11:0] lfsr_b(input logic [11:0] r);
    return {r[10:0], r[11] ^ r[5] ^ r[3] ^ r[0]};
  endfunction

  // Threshold comparators on two LFSRs give streams with pa = ta/4096, pb = tb/4096.
  task automatic stat_run(input logic [11:0] ta, input logic [11:0] tb, output int cnt);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      @(posedge CLK);
      #1;
      la = lfsr_a(la);
      lb = lfsr_b(lb);
      nRST = 1'b1; en = 1'b1; sat_clr = 1'b0;
      a = (la < ta);
      b = (lb < tb);
      stat_on = 1'b1;
    end
    @(posedge CLK);
    #1;
    stat_on = 1'b0; a = 1'b0; b = 1'b0;
    cnt = ones;
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      yv = mx.sel ? y4 : y8;
      nv = mx.sel ? neg4 : neg8;
      vectors++;
      if (yv !== mx.y) begin
        miscompares++;
        $display("FAIL %s y: got %b want %b at %0t", mx.nm, yv, mx.y, $time);
      end
      if (mx.cn) begin
        vectors++;
        if (nv !== mx.neg) begin
          miscompares++;
          $display("FAIL %s neg: got %b want %b at %0t", mx.nm, nv, mx.neg, $time);
        end
      end
`ifdef STOCH_SUB_SAT_FLAG_EN
      if (mx.cs) begin
        vectors++;
        if (sat4 !== mx.sat) begin
          miscompares++;
          $display("FAIL %s sat: got %b want %b at %0t", mx.nm, sat4, mx.sat, $time);
        end
      end
`endif
    end
    if (stat_on && y8) ones++;
  end

  initial begin
    nRST = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; sat_clr = 1'b0;
    la = 12'hACE; lb = 12'h5B3;

    // Reset with a live minuend, then neutral pairs
    vec8(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_y");
    vec8(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rst_neg");
    for (int i = 0; i < 8; i++) vec8(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "neutral");

    // Pure minuend, then 3 debt cycles and repayment
    for (int i = 0; i < 16; i++) vec8(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "minuend");
    for (int i = 0; i < 3; i++) vec8(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, i > 0, 1'b1, "debt");
    for (int i = 0; i < 5; i++) vec8(1'b1, 1'b1, 1'b1, 1'b0, i >= 3, i < 3, 1'b1, "repay");

    // Enable hold at counter -2
    vec8(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "hold_debt0");
    vec8(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "hold_debt1");
    for (int i = 0; i < 5; i++) vec8(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "hold");
    for (int i = 0; i < 3; i++) vec8(1'b1, 1'b1, 1'b1, 1'b0, i == 2, i < 2, 1'b1, "reenable");
    vec8(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "en_gate");

    // Saturation on the N=4 instance (minimum -8)
    vec8(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_sat");
    for (int i = 1; i <= 20; i++) vec4(1'b0, 1'b1, 1'b0, 1'b0, i > 1, i >= 10, "sat_fill");
    for (int i = 1; i <= 9; i++) vec4(1'b1, 1'b0, 1'b0, i == 9, i <= 8, 1'b1, "sat_repay");
    for (int i = 1; i <= 8; i++) vec4(1'b0, 1'b1, 1'b0, 1'b0, i > 1, 1'b1, "sat_refill");
    vec4(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_with_clamp");
    vec4(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "set_wins");
    vec4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sat_cleared");

    // Statistical accuracy on the N=8 instance
    vec8(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_stat");
    stat_run(12'd3072, 12'd1024, run_ones);
    vectors++;
    if (run_ones < 1984 || run_ones > 2112) begin
      miscompares++;
      $display("FAIL stat_075_025 ones: got %0d want 2048+-64", run_ones);
    end
    stat_run(12'd1024, 12'd3072, run_ones);
    vectors++;
    if (run_ones > 40) begin
      miscompares++;
      $display("FAIL stat_025_075 ones: got %0d want <= 40", run_ones);
    end

    // Reset mid-stream at counter -5
    vec8(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid0");
    for (int i = 0; i < 5; i++) vec8(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, i > 0, 1'b1, "debt5");
    vec8(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "mid_rst");
    vec8(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "post_rst");

    repeat (3) @(posedge CLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
